// File: rtl/loop_index_ctrl_pkg.sv
// Shared definitions for the loop index controller: state encodings and datapath width.
package loop_index_ctrl_pkg;

    localparam int unsigned LIC_DATAWIDTH = 2;

    typedef enum logic [1:0] {
        LIC_IDLE   = 2'd0,
        LIC_ISSUE  = 2'd1,
        LIC_FINISH = 2'd2
    } lic_state_e;

endpackage

// File: rtl/inc.sv
// Increment stage: combinational a+1, truncated to the datapath width.
module inc #(
    parameter int unsigned DATAWIDTH = 2
) (
    input  logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] y
);

    assign y = a + DATAWIDTH'(1);

endmodule

// File: rtl/loop_index_ctrl_index_reg.sv
// Loop index register: async reset, synchronous clear-to-zero, increment through the INC stage.
module loop_index_reg
    import loop_index_ctrl_pkg::*;
#(
    parameter int unsigned DATAWIDTH = LIC_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc_en,
    output logic [DATAWIDTH-1:0] q
);

    logic [DATAWIDTH-1:0] q_inc_c;

    inc #(.DATAWIDTH(DATAWIDTH)) u_inc (
        .a (q),
        .y (q_inc_c)
    );

    // Clear has priority so a restart always begins at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc_en) begin
            q <= q_inc_c;
        end
    end

endmodule

// File: rtl/loop_index_ctrl.sv
// Loop iteration controller: issues indices 0..bound-1 on a valid/ready stream with start/busy/done control.
module loop_index_ctrl
    import loop_index_ctrl_pkg::*;
#(
    parameter int unsigned DATAWIDTH = LIC_DATAWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] bound,
    input  logic                 abort,
    output logic [DATAWIDTH-1:0] index,
    output logic                 idx_valid,
    input  logic                 idx_ready,
    output logic                 busy,
    output logic                 done
);

    lic_state_e           state, state_d;
    logic [DATAWIDTH-1:0] bound_q, bound_d;
    logic                 valid_d, busy_d, done_d;
    logic                 idx_clr, idx_inc;
    logic                 hs;

    assign hs = idx_valid & idx_ready;

    loop_index_reg #(.DATAWIDTH(DATAWIDTH)) u_index_reg (
        .clk    (Clk),
        .rst    (Rst),
        .clr    (idx_clr),
        .inc_en (idx_inc),
        .q      (index)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= LIC_IDLE;
            bound_q   <= '0;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            bound_q   <= bound_d;
            idx_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // done is registered on entry to FINISH so it is high exactly while FINISH is held.
    always_comb begin
        state_d = state;
        bound_d = bound_q;
        valid_d = idx_valid;
        busy_d  = busy;
        done_d  = 1'b0;
        idx_clr = 1'b0;
        idx_inc = 1'b0;

        case (state)
            LIC_IDLE: begin
                if (start && !abort) begin
                    busy_d = 1'b1;
                    if (bound != '0) begin
                        bound_d = bound;
                        idx_clr = 1'b1;
                        valid_d = 1'b1;
                        state_d = LIC_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = LIC_FINISH;
                    end
                end
            end
            LIC_ISSUE: begin
                if (abort) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = LIC_IDLE;
                end else if (hs) begin
                    if (index == bound_q - DATAWIDTH'(1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = LIC_FINISH;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            LIC_FINISH: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = LIC_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = LIC_IDLE;
            end
        endcase
    end

endmodule
